// File: rtl/rr_arbiter_n.sv
// N-channel request arbiter for a single shared resource.
// Selectable fixed-priority or round-robin policy, direct handover between
// holders with no idle cycle, and optional preemption after MAX_HOLD cycles.
// Grant is registered and one-hot; grant_id and busy are derived from it.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  parameter int IDW      = 2,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   cand;
  logic [N-1:0]   others;
  logic [IDW-1:0] win;
  logic           do_new;

  // Winner search: fixed mode scans from index 0, round-robin scans upward
  // from the pointer and wraps modulo N. The first set bit wins.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r,
                                          input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (RR_MODE != 0) ? ((int'(p) + k) % N) : k;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = IDW'(idx);
      end
    end
    return w;
  endfunction

  // Next-state decision: new grant from idle, hold, release/handover, preempt.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    do_new  = 1'b0;
    cand    = '0;
    others  = req & ~grant_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          do_new = 1'b1;
          cand   = req;
        end
      end
      S_GRANT: begin
        if (!req[id_q]) begin
          // Release takes precedence over a coincident preemption.
          if (|req) begin
            do_new = 1'b1;
            cand   = req;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if ((MAX_HOLD > 0) && (cnt_q == CW'(MAX_HOLD)) && (|others)) begin
          do_new = 1'b1;
          cand   = others;
        end else if ((MAX_HOLD > 0) && (cnt_q == CW'(MAX_HOLD))) begin
          // Nobody else waiting: stay armed at the limit so a later arrival
          // preempts on the very next edge.
          cnt_d = cnt_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        cnt_d   = '0;
      end
    endcase

    win = pick(cand, ptr_q);
    if (do_new) begin
      state_d = S_GRANT;
      grant_d = N'(1) << win;
      id_d    = win;
      cnt_d   = CW'(1);
      ptr_d   = (int'(win) == N - 1) ? '0 : win + IDW'(1);
    end
  end

  // State, grant, pointer and hold-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = |grant_q;

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-channel arbiter. Successor to the 3-requester fixed-priority arbiter.
- Adds:
  - selectable fixed-priority or round-robin policy;
  - direct grant handover with no idle cycle;
  - optional maximum-hold preemption;
  - encoded grant index and busy flag.
- Sits between N request sources and one shared resource. Grants are registered and one-hot.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- RR_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round robin.
- MAX_HOLD, 0, maximum consecutive grant cycles before preemption when others are waiting; 0 = unlimited.
- IDW, 2, width of grant_id; must equal clog2(N).
- CW, 8, hold-counter width; MAX_HOLD must be < 2^CW.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- req, input, N, request vector; bit i is requester i.
- grant, output, N, registered one-hot (or zero) grant.
- grant_id, output, IDW, index of the granted requester; 0 when idle.
- busy, output, 1, high when any grant bit is set.

Behaviour:
- Reset (reset == 0 at a rising clk edge), next cycle: grant = 0, grant_id = 0, busy = 0, state = IDLE, RR pointer = 0, hold counter = 0.
  - Reset mid-grant drops the grant on the next edge, regardless of req.
- States:
  - IDLE: no holder.
  - GRANT: one holder h.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select a winner w using the policy below; at the next edge set grant = 1<<w, grant_id = w, go to GRANT, hold counter = 1.
  - Latency: req seen at edge k gives grant visible after edge k+1 (one cycle).
- Policy:
  - Fixed: lowest set index wins.
  - RR: search from index ptr upward, wrapping modulo N; the first set bit wins.
  - ptr is updated to (w+1) mod N on every new grant, including handovers.
  - In fixed mode ptr is ignored.
- GRANT, req[h] == 1:
  - Hold the grant.
  - Hold counter increments, saturating at 2^CW - 1.
- GRANT, req[h] == 0 (release):
  - If other requests are pending, select the next winner with the same policy and grant it at the next edge. No idle cycle; counter = 1.
  - Otherwise go to IDLE and clear grant.
- Preemption (MAX_HOLD > 0):
  - Condition: counter == MAX_HOLD, req[h] == 1, and at least one other req bit is set.
  - At the next edge, the grant moves to the winner selected with req[h] masked out; counter = 1.
  - If no other request is pending, h keeps the grant and the counter saturates.
  - When the others are gone, h can be regranted by the normal rules.
- Simultaneous release and preemption at the same edge: treat as a release (same result).
- Requests arriving while in GRANT do not affect the holder, except through preemption.
- Invariants:
  - grant has at most one bit set.
  - grant_id always equals the encoded grant.
  - busy == |grant.
  - grant[i] is never 1 in a cycle after req[i] was sampled 0 while holding, except for the single registered cycle of release latency.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with req = 4'b1111 -> grant = 0, busy = 0, grant_id = 0 throughout; first grant appears exactly 2 edges after reset rises.
- Fixed priority (RR_MODE = 0, N = 4): req = 4'b1010 -> grant = 4'b0010, grant_id = 1; drop req[1] -> next cycle grant = 4'b1000, grant_id = 3, no idle cycle.
- Round robin (RR_MODE = 1): keep req = 4'b1111 and pulse each holder's request low for one cycle in turn -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap-around).
- Preemption (MAX_HOLD = 3, RR): req = 4'b0011 held constant -> grant 0001 for exactly 3 cycles, then 0010 for 3 cycles, then 0001, repeating. With req = 4'b0001 only -> grant 0001 held indefinitely.
- Reset mid-operation: while grant = 0100, assert reset = 0 for 1 cycle -> grant = 0 the next cycle; ptr resets, so req = 4'b1111 afterwards gives grant 0001.
- Idle return: single req = 4'b0100 pulsed for 3 cycles, then 0 -> grant 0100 for 3 cycles, delayed by one cycle; then grant = 0, busy = 0.
